// File: rtl/counter_prog.sv
// Programmable up/down event counter: modulus, wrap or saturate, en prescaler,
// parallel load with clamp, one-cycle terminal-count pulse and sticky overflow.
module counter_prog #(
  parameter int              WIDTH    = 32,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter bit              SATURATE = 1'b0,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  // Top of range is formed in 64 bits so MODULUS == 2**WIDTH yields all-ones.
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'd1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;
  logic             step;
  logic             at_limit;
  logic             boundary;

  always_comb begin
    step      = en && (pre == PRE_LAST);
    at_limit  = up ? (count == MAX_VAL) : (count == '0);
    boundary  = 1'b0;
    count_nxt = count;
    pre_nxt   = pre;

    if (load) begin
      count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      pre_nxt   = '0;
    end else if (en) begin
      if (step) begin
        pre_nxt = '0;
        if (at_limit) begin
          boundary = 1'b1;
          if (!SATURATE) begin
            count_nxt = up ? '0 : MAX_VAL;
          end
        end else begin
          count_nxt = up ? (count + WIDTH'(1)) : (count - WIDTH'(1));
        end
      end else begin
        pre_nxt = pre + PW'(1);
      end
    end

    tc_nxt  = boundary;
    // A boundary step outranks a simultaneous clear.
    ovf_nxt = boundary | (ovf & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      pre   <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      pre   <= pre_nxt;
      tc    <= tc_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_counter_prog.sv
// Bench for counter_prog: four configurations share one stimulus stream and are
// compared against an arithmetic reference model plus directed scenario checks.
module tb_counter_prog;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic       clr_ovf;

  logic [3:0] cnt_w, cnt_s, cnt_p;
  logic [7:0] cnt_f;
  logic       tc_w, tc_s, tc_p, tc_f;
  logic       ovf_w, ovf_s, ovf_p, ovf_f;

  int checks   = 0;
  int failures = 0;

  counter_prog #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .PRESCALE(1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
    .clr_ovf(clr_ovf), .count(cnt_w), .tc(tc_w), .ovf(ovf_w));

  counter_prog #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .PRESCALE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
    .clr_ovf(clr_ovf), .count(cnt_s), .tc(tc_s), .ovf(ovf_s));

  counter_prog #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .PRESCALE(3)) u_pre (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
    .clr_ovf(clr_ovf), .count(cnt_p), .tc(tc_p), .ovf(ovf_p));

  counter_prog #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0), .PRESCALE(1)) u_full (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(cnt_f), .tc(tc_f), .ovf(ovf_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint unsigned cfg_mod(input int i);
    return (i == 3) ? 64'd256 : 64'd10;
  endfunction

  function automatic longint unsigned cfg_mask(input int i);
    return (i == 3) ? 64'd255 : 64'd15;
  endfunction

  function automatic bit cfg_sat(input int i);
    return (i == 1);
  endfunction

  function automatic int cfg_ps(input int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic longint unsigned dut_cnt(input int i);
    case (i)
      0:       return 64'(cnt_w);
      1:       return 64'(cnt_s);
      2:       return 64'(cnt_p);
      default: return 64'(cnt_f);
    endcase
  endfunction

  function automatic bit dut_tc(input int i);
    case (i)
      0:       return tc_w;
      1:       return tc_s;
      2:       return tc_p;
      default: return tc_f;
    endcase
  endfunction

  function automatic bit dut_ovf(input int i);
    case (i)
      0:       return ovf_w;
      1:       return ovf_s;
      2:       return ovf_p;
      default: return ovf_f;
    endcase
  endfunction

  // Reference model: value in 0..mod-1, pulses accepted modulo the prescale.
  longint unsigned m_cnt[4];
  int              m_pulses[4];
  bit              m_tc[4];
  bit              m_ovf[4];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] <= 0; m_pulses[i] <= 0; m_tc[i] <= 0; m_ovf[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        longint unsigned lv, top, nv;
        bit              hit;
        top = cfg_mod(i) - 1;
        lv  = 64'(load_val) & cfg_mask(i);
        hit = 0;
        nv  = m_cnt[i];
        if (load) begin
          nv = (lv > top) ? top : lv;
          m_pulses[i] <= 0;
        end else if (en) begin
          if (m_pulses[i] + 1 == cfg_ps(i)) begin
            m_pulses[i] <= 0;
            if (up) begin
              hit = (m_cnt[i] == top);
              nv  = (hit && cfg_sat(i)) ? m_cnt[i] : (m_cnt[i] + 1) % cfg_mod(i);
            end else begin
              hit = (m_cnt[i] == 0);
              nv  = hit ? (cfg_sat(i) ? 64'd0 : top) : m_cnt[i] - 1;
            end
          end else begin
            m_pulses[i] <= m_pulses[i] + 1;
          end
        end
        m_cnt[i] <= nv;
        m_tc[i]  <= hit;
        m_ovf[i] <= hit || (m_ovf[i] && !clr_ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    longint unsigned exp_c;
    rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 8'd0; clr_ovf = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_cnt(i) !== 0 || dut_tc(i) !== 1'b0 || dut_ovf(i) !== 1'b0) begin
        failures++;
        $display("FAIL reset_initial dut=%0d count=%0d tc=%0b ovf=%0b required 0/0/0",
                 i, dut_cnt(i), dut_tc(i), dut_ovf(i));
      end
    end
    tick(); tick();
    rst = 1'b1; load = 1'b1; load_val = 8'd4; en = 1'b1;
    tick();
    load = 1'b0;
    tick();
    checks++;
    if (cnt_w !== 4'd5) begin
      failures++;
      $display("FAIL reset_precount count=%0d required 5", cnt_w);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (cnt_w !== 4'd0 || tc_w !== 1'b0 || ovf_w !== 1'b0) begin
      failures++;
      $display("FAIL reset_async count=%0d tc=%0b ovf=%0b required 0/0/0", cnt_w, tc_w, ovf_w);
    end
    tick();
    checks++;
    if (cnt_w !== 4'd0) begin
      failures++;
      $display("FAIL reset_hold count=%0d required 0", cnt_w);
    end
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp_c = 64'(k);
      checks++;
      if (64'(cnt_w) !== exp_c) begin
        failures++;
        $display("FAIL reset_resume step=%0d count=%0d required %0d", k, cnt_w, exp_c);
      end
    end
  endtask

  task automatic test_wrap();
    load = 1'b1; load_val = 8'd0; clr_ovf = 1'b1; en = 1'b0;
    tick();
    load = 1'b0; clr_ovf = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (cnt_w !== 4'(k) || tc_w !== 1'b0 || ovf_w !== 1'b0) begin
        failures++;
        $display("FAIL wrap_count count=%0d tc=%0b ovf=%0b required %0d/0/0", cnt_w, tc_w, ovf_w, k);
      end
    end
    tick();
    checks++;
    if (cnt_w !== 4'd0 || tc_w !== 1'b1 || ovf_w !== 1'b1) begin
      failures++;
      $display("FAIL wrap_boundary count=%0d tc=%0b ovf=%0b required 0/1/1", cnt_w, tc_w, ovf_w);
    end
    tick();
    checks++;
    if (cnt_w !== 4'd1 || tc_w !== 1'b0 || ovf_w !== 1'b1) begin
      failures++;
      $display("FAIL wrap_after count=%0d tc=%0b ovf=%0b required 1/0/1", cnt_w, tc_w, ovf_w);
    end
    en = 1'b0; clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (ovf_w !== 1'b0) begin
      failures++;
      $display("FAIL wrap_clr_ovf ovf=%0b required 0", ovf_w);
    end
  endtask

  task automatic test_saturate();
    logic [3:0] exp_c [5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    logic       exp_t [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    load = 1'b1; load_val = 8'd2; clr_ovf = 1'b1; en = 1'b0;
    tick();
    checks++;
    if (cnt_s !== 4'd2 || ovf_s !== 1'b0) begin
      failures++;
      $display("FAIL sat_load count=%0d ovf=%0b required 2/0", cnt_s, ovf_s);
    end
    load = 1'b0; clr_ovf = 1'b0; en = 1'b1; up = 1'b0;
    for (int k = 0; k < 5; k++) begin
      clr_ovf = (k == 4);
      tick();
      checks++;
      if (cnt_s !== exp_c[k] || tc_s !== exp_t[k]) begin
        failures++;
        $display("FAIL sat_step edge=%0d count=%0d tc=%0b required %0d/%0b",
                 k + 1, cnt_s, tc_s, exp_c[k], exp_t[k]);
      end
    end
    checks++;
    if (ovf_s !== 1'b1) begin
      failures++;
      $display("FAIL sat_set_beats_clr ovf=%0b required 1", ovf_s);
    end
    en = 1'b0; clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (ovf_s !== 1'b0 || tc_s !== 1'b0) begin
      failures++;
      $display("FAIL sat_clr ovf=%0b tc=%0b required 0/0", ovf_s, tc_s);
    end
  endtask

  task automatic test_prescaler();
    logic       pat   [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_c [7] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
    logic [3:0] exp_r [4] = '{4'd5, 4'd5, 4'd5, 4'd6};
    up = 1'b1; load = 1'b1; load_val = 8'd0; en = 1'b0;
    tick();
    load = 1'b0;
    for (int k = 0; k < 7; k++) begin
      en = pat[k];
      tick();
      checks++;
      if (cnt_p !== exp_c[k]) begin
        failures++;
        $display("FAIL pre_phase edge=%0d count=%0d required %0d", k + 1, cnt_p, exp_c[k]);
      end
    end
    en = 1'b1;
    tick();
    load = 1'b1; load_val = 8'd5;
    tick();
    load = 1'b0;
    checks++;
    if (cnt_p !== exp_r[0]) begin
      failures++;
      $display("FAIL pre_load count=%0d required %0d", cnt_p, exp_r[0]);
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      checks++;
      if (cnt_p !== exp_r[k]) begin
        failures++;
        $display("FAIL pre_restart pulse=%0d count=%0d required %0d", k, cnt_p, exp_r[k]);
      end
    end
  endtask

  task automatic test_load_clamp();
    up = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'd15;
    tick();
    load = 1'b0;
    checks++;
    if (cnt_w !== 4'd9 || tc_w !== 1'b0 || cnt_p !== 4'd9) begin
      failures++;
      $display("FAIL load_clamp count=%0d tc=%0b pre_count=%0d required 9/0/9", cnt_w, tc_w, cnt_p);
    end
    tick();
    checks++;
    if (cnt_w !== 4'd0 || tc_w !== 1'b1) begin
      failures++;
      $display("FAIL load_then_wrap count=%0d tc=%0b required 0/1", cnt_w, tc_w);
    end
    tick();
    checks++;
    if (cnt_p !== 4'd9) begin
      failures++;
      $display("FAIL load_pre_cleared count=%0d required 9", cnt_p);
    end
    tick();
    checks++;
    if (cnt_p !== 4'd0 || tc_p !== 1'b1) begin
      failures++;
      $display("FAIL load_pre_wrap count=%0d tc=%0b required 0/1", cnt_p, tc_p);
    end
  endtask

  task automatic test_full_range();
    load = 1'b1; load_val = 8'd255; clr_ovf = 1'b1; en = 1'b0; up = 1'b1;
    tick();
    load = 1'b0; clr_ovf = 1'b0;
    checks++;
    if (cnt_f !== 8'd255 || ovf_f !== 1'b0) begin
      failures++;
      $display("FAIL full_load count=%0d ovf=%0b required 255/0", cnt_f, ovf_f);
    end
    en = 1'b1;
    tick();
    checks++;
    if (cnt_f !== 8'd0 || tc_f !== 1'b1 || ovf_f !== 1'b1) begin
      failures++;
      $display("FAIL full_wrap_up count=%0d tc=%0b ovf=%0b required 0/1/1", cnt_f, tc_f, ovf_f);
    end
    up = 1'b0;
    tick();
    checks++;
    if (cnt_f !== 8'd255 || tc_f !== 1'b1) begin
      failures++;
      $display("FAIL full_wrap_down count=%0d tc=%0b required 255/1", cnt_f, tc_f);
    end
    tick();
    checks++;
    if (cnt_f !== 8'd254 || tc_f !== 1'b0) begin
      failures++;
      $display("FAIL full_down count=%0d tc=%0b required 254/0", cnt_f, tc_f);
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      en       = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 2) != 0) ? up : ~up;
      load     = ($urandom_range(0, 24) == 0);
      load_val = 8'($urandom_range(0, 255));
      clr_ovf  = ($urandom_range(0, 11) == 0);
      tick();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dut_cnt(i) !== m_cnt[i] || dut_tc(i) !== m_tc[i] || dut_ovf(i) !== m_ovf[i]) begin
          failures++;
          $display("FAIL random cyc=%0d dut=%0d count=%0d tc=%0b ovf=%0b required %0d/%0b/%0b",
                   n, i, dut_cnt(i), dut_tc(i), dut_ovf(i), m_cnt[i], m_tc[i], m_ovf[i]);
        end
      end
    end
    load = 1'b0; en = 1'b0; clr_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_prescaler();
    test_load_clamp();
    test_full_range();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
